store_buffer: RTL and testbench



---
 rtl/store_buffer_if.sv | 27 ++
 rtl/store_buffer.sv | 110 +++++++++++
 tb/tb_store_buffer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// store_buffer_if: push, dmem drain and load-forward signals of the store buffer.
interface store_buffer_if;
  logic        push;
  logic [31:0] push_addr;
  logic [3:0]  push_wmask;
  logic [31:0] push_wdata;
  logic        store_buffer_full;
  logic        store_buffer_empty;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic        dmem_write;
  logic        dmem_resp;
  logic [31:0] ld_addr;
  logic [3:0]  fwd_mask;
  logic [31:0] fwd_data;
  modport master (
    output push, push_addr, push_wmask, push_wdata, dmem_resp, ld_addr,
    input  store_buffer_full, store_buffer_empty, dmem_addr, dmem_wmask, dmem_wdata, dmem_write,
           fwd_mask, fwd_data
  );
  modport slave (
    input  push, push_addr, push_wmask, push_wdata, dmem_resp, ld_addr,
    output store_buffer_full, store_buffer_empty, dmem_addr, dmem_wmask, dmem_wdata, dmem_write,
           fwd_mask, fwd_data
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: committed-store FIFO draining to dmem with load forwarding.
// Define STORE_BUFFER_COALESCE_EN to merge same-word pushes into the youngest entry.
module store_buffer #(
  parameter int SB_DEPTH    = 2,
  parameter int SB_NUM_ELEM = 2**SB_DEPTH
) (
  input logic          clk,
  input logic          rst,
  store_buffer_if.slave sb
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  typedef logic [SB_DEPTH-1:0] ptr_t;
  typedef logic [SB_DEPTH:0] cnt_t;
  logic [0:0]  state_q, state_d;
  ptr_t        head_q, head_d, tail_q, tail_d, young, idx;
  cnt_t        count_q, count_d;
  logic        valid_q [SB_NUM_ELEM];
  logic        valid_d [SB_NUM_ELEM];
  logic [29:0] addr_q  [SB_NUM_ELEM];
  logic [29:0] addr_d  [SB_NUM_ELEM];
  logic [3:0]  mask_q  [SB_NUM_ELEM];
  logic [3:0]  mask_d  [SB_NUM_ELEM];
  logic [31:0] data_q  [SB_NUM_ELEM];
  logic [31:0] data_d  [SB_NUM_ELEM];
  logic        full, busy, drain, accept, merge, unused_bits;
  logic [3:0]  fwd_mask;
  logic [31:0] fwd_data;
  assign full        = count_q == cnt_t'(SB_NUM_ELEM);
  assign busy        = state_q == BUSY;
  assign drain       = busy && sb.dmem_resp;
  assign accept      = sb.push && (!full || drain);
  assign young       = tail_q - ptr_t'(1);
  assign unused_bits = ^{sb.push_addr[1:0], sb.ld_addr[1:0]};
`ifdef STORE_BUFFER_COALESCE_EN
  assign merge = valid_q[young] && addr_q[young] == sb.push_addr[31:2] && !(busy && young == head_q);
`else
  assign merge = 1'b0;
`endif
  assign sb.store_buffer_full  = full;
  assign sb.store_buffer_empty = count_q == '0;
  assign sb.dmem_write         = busy;
  assign sb.dmem_addr          = busy ? {addr_q[head_q], 2'b00} : '0;
  assign sb.dmem_wmask         = busy ? mask_q[head_q] : '0;
  assign sb.dmem_wdata         = busy ? data_q[head_q] : '0;
  assign sb.fwd_mask           = fwd_mask;
  assign sb.fwd_data           = fwd_data;
  // A push that lands in the slot freed by a same-cycle drain overrides the clear.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    data_d  = data_q;
    head_d  = head_q + ptr_t'(drain);
    tail_d  = tail_q + ptr_t'(accept && !merge);
    count_d = count_q + cnt_t'(accept && !merge) - cnt_t'(drain);
    if (drain) valid_d[head_q] = 1'b0;
    if (accept && merge) begin
      mask_d[young] = mask_q[young] | sb.push_wmask;
      for (int b = 0; b < 4; b++)
        data_d[young][8*b +: 8] = sb.push_wmask[b] ? sb.push_wdata[8*b +: 8] : data_q[young][8*b +: 8];
    end else if (accept) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = sb.push_addr[31:2];
      mask_d[tail_q]  = sb.push_wmask;
      data_d[tail_q]  = sb.push_wdata;
    end
    state_d = !busy ? (count_q != '0 ? BUSY : IDLE) : (drain && count_d == '0 ? IDLE : BUSY);
  end
  // Walk oldest to youngest so younger matches overwrite older lanes.
  always_comb begin
    fwd_mask = '0;
    fwd_data = '0;
    idx      = head_q;
    for (int k = 0; k < SB_NUM_ELEM; k++) begin
      idx = head_q + ptr_t'(k);
      if (valid_q[idx] && addr_q[idx] == sb.ld_addr[31:2])
        for (int b = 0; b < 4; b++)
          if (mask_q[idx][b]) begin
            fwd_mask[b]          = 1'b1;
            fwd_data[8*b +: 8]   = data_q[idx][8*b +: 8];
          end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < SB_NUM_ELEM; i++) begin
        valid_q[i] <= 1'b0;
        addr_q[i]  <= '0;
        mask_q[i]  <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
    end
  end
  always_ff @(posedge clk)
    if (!rst) assert (!(sb.push && full && !drain));
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: table-driven vectors plus directed sequences for store_buffer.
module tb_store_buffer;
  typedef struct {
    logic        push;
    logic [31:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic        resp;
    logic [31:0] ld;
    logic        wr;
    logic [31:0] daddr;
    logic [3:0]  dmask;
    logic [31:0] ddata;
    logic        full;
    logic        empty;
    logic [3:0]  fmask;
    logic [31:0] fdata;
  } vec_t;
  localparam logic [31:0] LX = 32'hFFFF_FFF0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  vec_t v [21];
  logic [3:0]  m17, m19;
  logic [31:0] d17, d19;
  logic        w19, e19;
  store_buffer_if sb_if ();
  store_buffer dut (.clk(clk), .rst(rst), .sb(sb_if));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic drive(logic p, logic [31:0] a, logic [3:0] m, logic [31:0] d, logic r, logic [31:0] l);
    sb_if.push       = p;
    sb_if.push_addr  = a;
    sb_if.push_wmask = m;
    sb_if.push_wdata = d;
    sb_if.dmem_resp  = r;
    sb_if.ld_addr    = l;
  endtask
  task automatic chk_dmem(string n, logic w, logic [31:0] a, logic [3:0] m, logic [31:0] d, logic e);
    chk({n, " dmem_write"}, 32'(sb_if.dmem_write), 32'(w));
    chk({n, " dmem_addr"}, sb_if.dmem_addr, a);
    chk({n, " dmem_wmask"}, 32'(sb_if.dmem_wmask), 32'(m));
    chk({n, " dmem_wdata"}, sb_if.dmem_wdata, d);
    chk({n, " empty"}, 32'(sb_if.store_buffer_empty), 32'(e));
  endtask
  initial begin
`ifdef STORE_BUFFER_COALESCE_EN
    m17 = 4'h3; d17 = 32'h0000BBCC; w19 = 1'b0; m19 = 4'h0; d19 = 32'h0; e19 = 1'b1;
`else
    m17 = 4'h1; d17 = 32'h000000AA; w19 = 1'b1; m19 = 4'h3; d19 = 32'h0000BBCC; e19 = 1'b0;
`endif
    v[0]  = '{1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 1'b0, 32'h100, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 4'hF, 32'hDEADBEEF};
    v[1]  = '{1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h100, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 4'hF, 32'hDEADBEEF};
    v[2]  = v[1];
    v[3]  = v[1];
    v[4]  = v[1];
    v[5]  = '{1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 4'h0, 32'h0};
    v[6]  = '{1'b0, 32'h0, 4'h0, 32'h0, 1'b0, LX, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 4'h0, 32'h0};
    v[7]  = '{1'b1, 32'h10, 4'hF, 32'h11111111, 1'b0, LX, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0};
    v[8]  = '{1'b1, 32'h14, 4'hF, 32'h22222222, 1'b0, LX, 1'b1, 32'h10, 4'hF, 32'h11111111, 1'b0, 1'b0, 4'h0, 32'h0};
    v[9]  = '{1'b1, 32'h18, 4'hF, 32'h33333333, 1'b0, LX, 1'b1, 32'h10, 4'hF, 32'h11111111, 1'b0, 1'b0, 4'h0, 32'h0};
    v[10] = '{1'b1, 32'h1C, 4'hF, 32'h44444444, 1'b0, LX, 1'b1, 32'h10, 4'hF, 32'h11111111, 1'b1, 1'b0, 4'h0, 32'h0};
    v[11] = '{1'b1, 32'h20, 4'hF, 32'h55555555, 1'b1, LX, 1'b1, 32'h14, 4'hF, 32'h22222222, 1'b1, 1'b0, 4'h0, 32'h0};
    v[12] = '{1'b0, 32'h0, 4'h0, 32'h0, 1'b1, LX, 1'b1, 32'h18, 4'hF, 32'h33333333, 1'b0, 1'b0, 4'h0, 32'h0};
    v[13] = '{1'b0, 32'h0, 4'h0, 32'h0, 1'b1, LX, 1'b1, 32'h1C, 4'hF, 32'h44444444, 1'b0, 1'b0, 4'h0, 32'h0};
    v[14] = '{1'b0, 32'h0, 4'h0, 32'h0, 1'b1, LX, 1'b1, 32'h20, 4'hF, 32'h55555555, 1'b0, 1'b0, 4'h0, 32'h0};
    v[15] = '{1'b0, 32'h0, 4'h0, 32'h0, 1'b1, LX, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 4'h0, 32'h0};
    v[16] = '{1'b1, 32'h200, 4'h1, 32'h000000AA, 1'b0, 32'h202, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 4'h1, 32'h000000AA};
    v[17] = '{1'b1, 32'h200, 4'h3, 32'h0000BBCC, 1'b0, 32'h202, 1'b1, 32'h200, m17, d17, 1'b0, 1'b0, 4'h3, 32'h0000BBCC};
    v[18] = '{1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h204, 1'b1, 32'h200, m17, d17, 1'b0, 1'b0, 4'h0, 32'h0};
    v[19] = '{1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h204, w19, w19 ? 32'h200 : 32'h0, m19, d19, 1'b0, e19, 4'h0, 32'h0};
    v[20] = '{1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h204, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 4'h0, 32'h0};
    drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, LX);
    step();
    step();
    chk_dmem("reset", 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    chk("reset full", 32'(sb_if.store_buffer_full), 32'h0);
    chk("reset fwd_mask", 32'(sb_if.fwd_mask), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 21; i++) begin
      drive(v[i].push, v[i].addr, v[i].wmask, v[i].wdata, v[i].resp, v[i].ld);
      step();
      chk_dmem($sformatf("v%0d", i), v[i].wr, v[i].daddr, v[i].dmask, v[i].ddata, v[i].empty);
      chk($sformatf("v%0d full", i), 32'(sb_if.store_buffer_full), 32'(v[i].full));
      chk($sformatf("v%0d fwd_mask", i), 32'(sb_if.fwd_mask), 32'(v[i].fmask));
      chk($sformatf("v%0d fwd_data", i), sb_if.fwd_data, v[i].fdata);
    end
    drive(1'b1, 32'h400, 4'hF, 32'h0, 1'b0, 32'h300);
    step();
    drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h300);
    step();
    chk_dmem("co busy", 1'b1, 32'h400, 4'hF, 32'h0, 1'b0);
    drive(1'b1, 32'h300, 4'h1, 32'h11, 1'b0, 32'h300);
    step();
    chk("co fwd1 mask", 32'(sb_if.fwd_mask), 32'h1);
    chk("co fwd1 data", sb_if.fwd_data, 32'h11);
    drive(1'b1, 32'h300, 4'h4, 32'h00220000, 1'b0, 32'h300);
    step();
    chk("co fwd2 mask", 32'(sb_if.fwd_mask), 32'h5);
    chk("co fwd2 data", sb_if.fwd_data, 32'h00220011);
    drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, LX);
    step();
`ifdef STORE_BUFFER_COALESCE_EN
    chk_dmem("co drain1", 1'b1, 32'h300, 4'h5, 32'h00220011, 1'b0);
    step();
    chk_dmem("co drain2", 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
`else
    chk_dmem("co drain1", 1'b1, 32'h300, 4'h1, 32'h11, 1'b0);
    step();
    chk_dmem("co drain2", 1'b1, 32'h300, 4'h4, 32'h00220000, 1'b0);
`endif
    step();
    chk_dmem("co drain3", 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    drive(1'b1, 32'h500, 4'hF, 32'hCAFEF00D, 1'b0, LX);
    step();
    drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, LX);
    step();
    chk_dmem("rst busy", 1'b1, 32'h500, 4'hF, 32'hCAFEF00D, 1'b0);
    rst = 1'b1;
    step();
    chk_dmem("rst mid", 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    rst = 1'b0;
    sb_if.dmem_resp = 1'b1;
    step();
    chk_dmem("rst stray resp", 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    sb_if.dmem_resp = 1'b0;
    step();
    chk_dmem("rst idle", 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    drive(1'b1, 32'h600, 4'hF, 32'h12345678, 1'b0, LX);
    step();
    drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, LX);
    step();
    chk_dmem("post rst push", 1'b1, 32'h600, 4'hF, 32'h12345678, 1'b0);
    sb_if.dmem_resp = 1'b1;
    step();
    sb_if.dmem_resp = 1'b0;
    chk_dmem("post rst drain", 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
